// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, field layouts,
// load-op codes, stall-vector positions and the read-data hold FSM states.
package mem_stage_pkg;

  localparam int unsigned EX_TO_MEM_WD = 79;
  localparam int unsigned MEM_TO_WB_WD = 70;
  localparam int unsigned HILO_WD      = 66;
  localparam int unsigned STALL_WD     = 6;

  // Stall vector positions and levels.
  localparam int unsigned StallMem = 3;
  localparam int unsigned StallWb  = 4;
  localparam logic        Stop     = 1'b1;
  localparam logic        NoStop   = 1'b0;

  typedef enum logic [2:0] {
    LoadLW  = 3'b000,
    LoadLB  = 3'b001,
    LoadLBU = 3'b010,
    LoadLH  = 3'b011,
    LoadLHU = 3'b100
  } load_op_e;

  // FRESH: use live SRAM data. HELD: use the copy taken on the first stalled edge.
  typedef enum logic [0:0] {
    StFresh = 1'b0,
    StHeld  = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  load_op;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        hi_we;
    logic        lo_we;
  } hilo_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_to_wb_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment and extension.
// Ports:
//   rdata_i   - 32-bit word read from the data SRAM
//   addr_i    - low two bits of the effective address
//   load_op_i - load opcode (LW/LB/LBU/LH/LHU; unknown codes act as LW)
//   value_o   - selected and sign/zero-extended load value
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  load_op_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[7:0];
    unique case (addr_i)
      2'd0: byte_v = rdata_i[7:0];
      2'd1: byte_v = rdata_i[15:8];
      2'd2: byte_v = rdata_i[23:16];
      2'd3: byte_v = rdata_i[31:24];
      default: byte_v = rdata_i[7:0];
    endcase
    // Halfword select ignores addr[0]; misalignment is flagged elsewhere if at all.
    half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    value_o = rdata_i;
    case (load_op_i)
      LoadLB:  value_o = {{24{byte_v[7]}}, byte_v};
      LoadLBU: value_o = {24'h0, byte_v};
      LoadLH:  value_o = {{16{half_v[15]}}, half_v};
      LoadLHU: value_o = {16'h0, half_v};
      default: value_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM and HI/LO buses under stall control,
// aligns/extends SRAM load data, builds the MEM->WB buses and drives forwarding.
// A stalled load keeps the SRAM word it saw on its first stalled cycle.
// Optional: MEM_ADDR_CHECK_EN adds mem_addr_err_o and suppresses the register
// write of misaligned LW/LH/LHU loads.
// Ports:
//   clk_i, rst_i            - clock, synchronous active-high reset
//   stall_i                 - stall vector ([3]=MEM, [4]=WB)
//   ex_to_mem_bus_i         - EX->MEM bus
//   hilo_ex_to_mem_bus_i    - HI/LO bus from EX
//   data_sram_rdata_i       - SRAM read data (valid the cycle after request)
//   mem_to_wb_bus_o         - MEM->WB bus
//   hilo_mem_to_wb_bus_o    - registered HI/LO bus
//   mem_wreg_o/waddr/wdata  - GPR forwarding to decode
//   mem_hi_*/mem_lo_*       - HI/LO forwarding to decode
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned EX_TO_MEM_WD = 79,
  parameter int unsigned MEM_TO_WB_WD = 70,
  parameter int unsigned HILO_WD      = 66
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [STALL_WD-1:0]     stall_i,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus_i,
  input  logic [HILO_WD-1:0]      hilo_ex_to_mem_bus_i,
  input  logic [31:0]             data_sram_rdata_i,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus_o,
  output logic [HILO_WD-1:0]      hilo_mem_to_wb_bus_o,
  output logic                    mem_wreg_o,
  output logic [4:0]              mem_waddr_o,
  output logic [31:0]             mem_wdata_o,
  output logic                    mem_hi_we_o,
  output logic                    mem_lo_we_o,
  output logic [31:0]             mem_hi_wdata_o,
  output logic [31:0]             mem_lo_wdata_o
`ifdef MEM_ADDR_CHECK_EN
  ,
  output logic                    mem_addr_err_o
`endif
);

  ex_to_mem_t ex_d, ex_q;
  hilo_t      hilo_d, hilo_q;
  rd_state_e  state_d, state_q;
  logic [31:0] rdata_d, rdata_q;

  logic stall_mem, stall_wb;
  assign stall_mem = stall_i[StallMem];
  assign stall_wb  = stall_i[StallWb];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q    <= '0;
      hilo_q  <= '0;
      state_q <= StFresh;
      rdata_q <= '0;
    end else begin
      ex_q    <= ex_d;
      hilo_q  <= hilo_d;
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    ex_d    = ex_q;
    hilo_d  = hilo_q;
    state_d = state_q;
    rdata_d = rdata_q;
    if (stall_mem == Stop && stall_wb == NoStop) begin
      // MEM stalls while WB moves on: hand WB a bubble.
      ex_d    = '0;
      hilo_d  = '0;
      state_d = StFresh;
    end else if (stall_mem == NoStop) begin
      ex_d    = ex_to_mem_t'(ex_to_mem_bus_i);
      hilo_d  = hilo_t'(hilo_ex_to_mem_bus_i);
      state_d = StFresh;
    end else if (state_q == StFresh) begin
      // First stalled edge: the SRAM word is valid now and may change later.
      rdata_d = data_sram_rdata_i;
      state_d = StHeld;
    end
  end

  logic [31:0] load_src, load_val;
  logic        addr_err;
  mem_to_wb_t  wb;

  assign load_src = (state_q == StHeld) ? rdata_q : data_sram_rdata_i;

  mem_stage_load_align u_load_align (
    .rdata_i   (load_src),
    .addr_i    (ex_q.ex_result[1:0]),
    .load_op_i (ex_q.load_op),
    .value_o   (load_val)
  );

`ifdef MEM_ADDR_CHECK_EN
  logic is_half, is_word;
  assign is_half  = (ex_q.load_op == LoadLH) || (ex_q.load_op == LoadLHU);
  assign is_word  = !(is_half || ex_q.load_op == LoadLB || ex_q.load_op == LoadLBU);
  assign addr_err = ex_q.sel_rf_res &&
                    ((is_half && ex_q.ex_result[0]) || (is_word && ex_q.ex_result[1:0] != 2'b00));
  assign mem_addr_err_o = addr_err;
`else
  assign addr_err = 1'b0;
`endif

  always_comb begin
    wb.pc       = ex_q.pc;
    wb.rf_we    = ex_q.rf_we && !addr_err;
    wb.rf_waddr = ex_q.rf_waddr;
    wb.rf_wdata = ex_q.sel_rf_res ? load_val : ex_q.ex_result;
  end

  assign mem_to_wb_bus_o      = wb;
  assign hilo_mem_to_wb_bus_o = hilo_q;

  assign mem_wreg_o     = wb.rf_we;
  assign mem_waddr_o    = wb.rf_waddr;
  assign mem_wdata_o    = wb.rf_wdata;
  assign mem_hi_we_o    = hilo_q.hi_we;
  assign mem_lo_we_o    = hilo_q.lo_we;
  assign mem_hi_wdata_o = hilo_q.hi_wdata;
  assign mem_lo_wdata_o = hilo_q.lo_wdata;

  // Store controls and unrelated stall bits are not consumed by this stage.
  logic unused_sig;
  assign unused_sig = ^{ex_q.data_ram_en, ex_q.data_ram_wen, stall_i[2:0], stall_i[5]};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [78:0] exb;
  logic [65:0] hlb;
  logic [31:0] rdata;

  logic [69:0] wb_bus;
  logic [65:0] hilo_out;
  logic        wreg, hi_we, lo_we;
  logic [4:0]  waddr;
  logic [31:0] wdata, hi_wdata, lo_wdata;
`ifdef MEM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: what the stage should currently hold.
  logic [78:0] m_bus;
  logic [65:0] m_hilo;
  bit          m_frozen;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .stall_i              (stall),
    .ex_to_mem_bus_i      (exb),
    .hilo_ex_to_mem_bus_i (hlb),
    .data_sram_rdata_i    (rdata),
    .mem_to_wb_bus_o      (wb_bus),
    .hilo_mem_to_wb_bus_o (hilo_out),
    .mem_wreg_o           (wreg),
    .mem_waddr_o          (waddr),
    .mem_wdata_o          (wdata),
    .mem_hi_we_o          (hi_we),
    .mem_lo_we_o          (lo_we),
    .mem_hi_wdata_o       (hi_wdata),
`ifdef MEM_ADDR_CHECK_EN
    .mem_addr_err_o       (addr_err),
`endif
    .mem_lo_wdata_o       (lo_wdata)
  );

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] mk(input logic [31:0] pc, input logic [2:0] op,
                                     input logic sel, input logic we, input logic [4:0] wa,
                                     input logic [31:0] res);
    return 80'({pc, op, sel, 4'h0, sel, we, wa, res});
  endfunction

  // Load result from arithmetic on the word: shift down, then extend by value range.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] d);
    longint v;
    case (op)
      3'd1, 3'd2: v = longint'((d >> (8 * a)) % 256);
      3'd3, 3'd4: v = longint'((d >> (16 * (a / 2))) % 65536);
      default:    v = longint'(d);
    endcase
    if (op == 3'd1 && v >= 128)   v = v - 256;
    if (op == 3'd3 && v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  function automatic bit ref_err(input logic [2:0] op, input logic [1:0] a, input logic sel);
`ifdef MEM_ADDR_CHECK_EN
    if (!sel) return 1'b0;
    if (op == 3'd3 || op == 3'd4) return a % 2 == 1;
    if (op == 3'd1 || op == 3'd2) return 1'b0;
    return a != 2'd0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all();
    logic [31:0] pc, res, src, wd;
    logic [2:0]  op;
    logic        sel, we;
    logic [4:0]  wa;
    bit          err;
    pc  = m_bus[78:47];
    op  = m_bus[46:44];
    sel = m_bus[38];
    we  = m_bus[37];
    wa  = m_bus[36:32];
    res = m_bus[31:0];
    src = m_frozen ? m_rdata : rdata;
    err = ref_err(op, res[1:0], sel);
    wd  = sel ? ref_load(op, res[1:0], src) : res;
    check("wb_bus", 80'(wb_bus), 80'({pc, we & ~err, wa, wd}));
    check("hilo_bus", 80'(hilo_out), 80'(m_hilo));
    check("fwd_wreg", 80'(wreg), 80'(we & ~err));
    check("fwd_waddr", 80'(waddr), 80'(wa));
    check("fwd_wdata", 80'(wdata), 80'(wd));
    check("fwd_hi_we", 80'(hi_we), 80'(m_hilo[1]));
    check("fwd_lo_we", 80'(lo_we), 80'(m_hilo[0]));
    check("fwd_hi_wdata", 80'(hi_wdata), 80'(m_hilo[65:34]));
    check("fwd_lo_wdata", 80'(lo_wdata), 80'(m_hilo[33:2]));
`ifdef MEM_ADDR_CHECK_EN
    check("addr_err", 80'(addr_err), 80'(err));
`endif
  endtask

  // Drive one cycle's inputs away from the edge, then compare against the model.
  task automatic apply(input logic r, input logic [5:0] s, input logic [79:0] b,
                       input logic [65:0] h, input logic [31:0] d);
    @(negedge clk);
    rst   = r;
    stall = s;
    exb   = b[78:0];
    hlb   = h;
    rdata = d;
    #1;
    check_all();
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_bus = '0; m_hilo = '0; m_frozen = 0; m_rdata = '0;
    end else if (stall[3] && !stall[4]) begin
      m_bus = '0; m_hilo = '0; m_frozen = 0;
    end else if (!stall[3]) begin
      m_bus = exb; m_hilo = hlb; m_frozen = 0;
    end else if (!m_frozen) begin
      m_frozen = 1; m_rdata = rdata;
    end
  endtask

  initial begin
    logic [79:0] lw_bus, alu_bus;
    logic [65:0] alu_hilo;
    rst = 1'b1; stall = '0; exb = '0; hlb = '0; rdata = '0;
    m_bus = '0; m_hilo = '0; m_frozen = 0; m_rdata = '0;
    tick();

    // Reset state: every output zero.
    apply(1'b1, 6'h0, '0, '0, 32'hFFFF_FFFF);
    check("rst_wb_bus", 80'(wb_bus), 80'h0);
    check("rst_hilo", 80'(hilo_out), 80'h0);
    tick();

    // Byte/half extraction.
    apply(0, 6'h0, mk(32'h100, 3'd1, 1, 1, 5'd3, 32'h1003), '0, '0);
    tick();
    apply(0, 6'h0, mk(32'h104, 3'd2, 1, 1, 5'd3, 32'h1003), '0, 32'h80FF_1234);
    check("lb_addr3", 80'(wdata), 80'hFFFF_FF80);
    tick();
    apply(0, 6'h0, mk(32'h108, 3'd3, 1, 1, 5'd4, 32'h2002), '0, 32'h80FF_1234);
    check("lbu_addr3", 80'(wdata), 80'h0000_0080);
    tick();
    apply(0, 6'h0, mk(32'h10C, 3'd4, 1, 1, 5'd4, 32'h2000), '0, 32'h8001_7FFF);
    check("lh_addr2", 80'(wdata), 80'hFFFF_8001);
    tick();
    lw_bus = mk(32'h110, 3'd0, 1, 1, 5'd7, 32'h3000);
    apply(0, 6'h0, lw_bus, '0, 32'h8001_7FFF);
    check("lhu_addr0", 80'(wdata), 80'h0000_7FFF);
    tick();

    // Stalled LW keeps the first word even as the SRAM output moves on.
    apply(0, 6'b011000, lw_bus, '0, 32'hAAAA_AAAA);
    check("lw_stall0", 80'(wdata), 80'hAAAA_AAAA);
    tick();
    for (int i = 1; i <= 3; i++) begin
      apply(0, 6'b011000, lw_bus, '0, 32'h5555_5555);
      check("lw_stall_hold", 80'(wdata), 80'hAAAA_AAAA);
      tick();
    end

    // Bubble when MEM stops and WB does not.
    alu_bus  = mk(32'h200, 3'd0, 0, 1, 5'd5, 32'h1234);
    alu_hilo = {32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0};
    apply(0, 6'b001000, alu_bus, alu_hilo, '0);
    tick();
    apply(0, 6'h0, alu_bus, alu_hilo, '0);
    check("bubble_wb", 80'(wb_bus), 80'h0);
    check("bubble_wreg", 80'(wreg), 80'h0);
    check("bubble_hilo", 80'(hilo_out), 80'h0);
    tick();

    // ALU result plus HI write forwarding.
    apply(0, 6'h0, mk(32'h300, 3'd0, 1, 1, 5'd9, 32'h4002), '0, 32'h1234_5678);
    check("alu_wdata", 80'(wdata), 80'h1234);
    check("alu_waddr", 80'(waddr), 80'd5);
    check("alu_hi", 80'(hi_wdata), 80'hDEAD_BEEF);
    tick();

    // Misaligned LW.
    apply(0, 6'h0, '0, '0, 32'h1234_5678);
`ifdef MEM_ADDR_CHECK_EN
    check("mis_lw_err", 80'(addr_err), 80'd1);
    check("mis_lw_wreg", 80'(wreg), 80'd0);
`else
    check("mis_lw_wreg", 80'(wreg), 80'd1);
    check("mis_lw_wdata", 80'(wdata), 80'h1234_5678);
`endif
    tick();

    // Random traffic including stalls, bubbles and resets.
    for (int i = 0; i < 400; i++) begin
      logic [5:0] s;
      s    = 6'($urandom);
      s[3] = ($urandom_range(0, 2) == 0);
      apply(($urandom_range(0, 39) == 0), s, 80'({$urandom, $urandom, $urandom}),
            66'({$urandom, $urandom, $urandom}), $urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
